// File: rtl/can_tx_mailbox_arbiter.sv
// rtl/can_tx_mailbox_arbiter.sv - priority arbiter sharing one CAN transmit engine among N mailboxes
module can_tx_mailbox_arbiter #(
  parameter int N_MBOX     = 4,
  parameter int ID_W       = 11,
  parameter int DATA_W     = 8,
  parameter int MAX_RETRY  = 3,
  parameter int IFS_CYCLES = 3,
  parameter int TIMEOUT    = 1023
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_MBOX-1:0]        req,
  input  logic [N_MBOX*ID_W-1:0]   id_flat,
  input  logic [N_MBOX*DATA_W-1:0] data_flat,
  output logic                     tx_start,
  output logic [ID_W-1:0]          tx_id,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_done,
  input  logic                     tx_arb_lost,
  output logic [N_MBOX-1:0]        grant,
  output logic [N_MBOX-1:0]        done,
  output logic [N_MBOX-1:0]        fail,
  output logic                     busy
);

  localparam int OW = $clog2(N_MBOX);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int GW = $clog2(IFS_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [RW-1:0]     RETRY_LAST = RW'(MAX_RETRY);
  localparam logic [GW-1:0]     GAP_LAST   = GW'(IFS_CYCLES - 1);
  localparam logic [WW-1:0]     WD_LAST    = WW'(TIMEOUT - 1);
  localparam logic [N_MBOX-1:0] ONE_HOT0   = N_MBOX'(1);

  // Registered state
  logic [1:0]        state_q,      state_d;
  logic [OW-1:0]     owner_q,      owner_d;
  logic [ID_W-1:0]   tx_id_q,      tx_id_d;
  logic [DATA_W-1:0] tx_data_q,    tx_data_d;
  logic              tx_start_q,   tx_start_d;
  logic [N_MBOX-1:0] grant_q,      grant_d;
  logic [N_MBOX-1:0] done_q,       done_d;
  logic [N_MBOX-1:0] fail_q,       fail_d;
  logic [RW-1:0]     retry_q,      retry_d;
  logic [OW-1:0]     last_owner_q, last_owner_d;
  logic              last_valid_q, last_valid_d;
  logic [GW-1:0]     gap_q,        gap_d;
  logic [WW-1:0]     wd_q,         wd_d;

  // Arbitration result
  logic              win_found;
  logic [OW-1:0]     win_idx;
  logic [ID_W-1:0]   win_id;
  logic [RW-1:0]     retry_inc;

  // Lowest ID among requesters wins; strict compare keeps the lowest index on ties
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_id    = '0;
    for (int i = 0; i < N_MBOX; i++) begin
      if (req[i] && (!win_found || (id_flat[i*ID_W +: ID_W] < win_id))) begin
        win_found = 1'b1;
        win_idx   = OW'(i);
        win_id    = id_flat[i*ID_W +: ID_W];
      end
    end
  end

  assign retry_inc = retry_q + RW'(1);

  // Next-state logic for the launch / wait / gap sequence
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    tx_id_d      = tx_id_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    grant_d      = grant_q;
    done_d       = '0;
    fail_d       = '0;
    retry_d      = retry_q;
    last_owner_d = last_owner_q;
    last_valid_d = last_valid_q;
    gap_d        = gap_q;
    wd_d         = wd_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          owner_d = win_idx;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // Snapshot ID and payload so later host writes cannot disturb the frame
        tx_id_d    = id_flat[int'(owner_q)*ID_W +: ID_W];
        tx_data_d  = data_flat[int'(owner_q)*DATA_W +: DATA_W];
        grant_d    = ONE_HOT0 << owner_q;
        // A different mailbox starts its own retry budget from zero
        if (!last_valid_q || (last_owner_q != owner_q)) begin
          retry_d      = '0;
          last_owner_d = owner_q;
          last_valid_d = 1'b1;
        end
        tx_start_d = 1'b1;
        wd_d       = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (tx_done) begin
          // Success takes precedence over a simultaneous arbitration loss
          done_d  = ONE_HOT0 << owner_q;
          grant_d = '0;
          retry_d = '0;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (tx_arb_lost) begin
          grant_d = '0;
          gap_d   = '0;
          state_d = S_GAP;
          if (retry_inc == RETRY_LAST) begin
            fail_d       = ONE_HOT0 << owner_q;
            retry_d      = '0;
            last_valid_d = 1'b0;
          end else begin
            retry_d = retry_inc;
          end
        end else if (wd_q == WD_LAST) begin
          // Transmitter never answered: give up on this frame
          fail_d       = ONE_HOT0 << owner_q;
          grant_d      = '0;
          retry_d      = '0;
          last_valid_d = 1'b0;
          gap_d        = '0;
          state_d      = S_GAP;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end

      S_GAP: begin
        // Inter-frame space; requests are only looked at again once back in IDLE
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything without issuing pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      tx_id_q      <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      grant_q      <= '0;
      done_q       <= '0;
      fail_q       <= '0;
      retry_q      <= '0;
      last_owner_q <= '0;
      last_valid_q <= 1'b0;
      gap_q        <= '0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      tx_id_q      <= tx_id_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      retry_q      <= retry_d;
      last_owner_q <= last_owner_d;
      last_valid_q <= last_valid_d;
      gap_q        <= gap_d;
      wd_q         <= wd_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_id    = tx_id_q;
  assign tx_data  = tx_data_q;
  assign grant    = grant_q;
  assign done     = done_q;
  assign fail     = fail_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_can_tx_mailbox_arbiter.sv
// tb/tb_can_tx_mailbox_arbiter.sv - directed self-checking bench for can_tx_mailbox_arbiter
module tb_can_tx_mailbox_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [43:0] id_flat;
  logic [31:0] data_flat;
  logic        tx_start;
  logic [10:0] tx_id;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        tx_arb_lost;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [3:0]  fail;
  logic        busy;

  int checks;
  int errors;
  int cyc;

  can_tx_mailbox_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .id_flat     (id_flat),
    .data_flat   (data_flat),
    .tx_start    (tx_start),
    .tx_id       (tx_id),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .tx_arb_lost (tx_arb_lost),
    .grant       (grant),
    .done        (done),
    .fail        (fail),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mbox(input int i, input logic [10:0] id, input logic [7:0] d);
    id_flat[i*11 +: 11] = id;
    data_flat[i*8 +: 8] = d;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (tx_start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 32'h0);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic pulse_lost();
    tx_arb_lost = 1'b1;
    @(negedge clk);
    tx_arb_lost = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    req         = 4'b0000;
    id_flat     = '0;
    data_flat   = '0;
    tx_done     = 1'b0;
    tx_arb_lost = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 32'h0);
    chk("rst_grant",    32'(grant),    32'h0);
    chk("rst_done",     32'(done),     32'h0);
    chk("rst_fail",     32'(fail),     32'h0);
    chk("rst_busy",     32'(busy),     32'h0);
    chk("rst_tx_id",    32'(tx_id),    32'h0);
    chk("rst_tx_data",  32'(tx_data),  32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'h0);

    // Test 1: single request, launch latency, snapshot, done and gap length
    set_mbox(2, 11'h123, 8'hA5);
    req = 4'b0100;
    @(negedge clk);
    chk("t1_load_no_start", 32'(tx_start), 32'h0);
    chk("t1_load_busy",     32'(busy),     32'h1);
    @(negedge clk);
    chk("t1_start",   32'(tx_start), 32'h1);
    chk("t1_tx_id",   32'(tx_id),    32'h123);
    chk("t1_tx_data", 32'(tx_data),  32'hA5);
    chk("t1_grant",   32'(grant),    32'h4);
    set_mbox(2, 11'h7AA, 8'h11);
    @(negedge clk);
    chk("t1_start_one_cycle", 32'(tx_start), 32'h0);
    chk("t1_snap_id",         32'(tx_id),    32'h123);
    chk("t1_snap_data",       32'(tx_data),  32'hA5);
    pulse_done();
    req = 4'b0000;
    chk("t1_done",       32'(done),  32'h4);
    chk("t1_grant_clr",  32'(grant), 32'h0);
    chk("t1_no_fail",    32'(fail),  32'h0);
    chk("t1_gap_busy1",  32'(busy),  32'h1);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done),  32'h0);
    chk("t1_gap_busy2",  32'(busy),  32'h1);
    @(negedge clk);
    chk("t1_gap_busy3",  32'(busy),  32'h1);
    @(negedge clk);
    chk("t1_idle_after_gap", 32'(busy), 32'h0);

    // Test 2: priority with equal IDs
    set_mbox(0, 11'h300, 8'h01);
    set_mbox(1, 11'h050, 8'h02);
    set_mbox(2, 11'h050, 8'h03);
    set_mbox(3, 11'h7FF, 8'h04);
    req = 4'b1111;
    wait_start(cyc);
    chk("t2_latency", 32'(cyc),     32'd2);
    chk("t2_grant",   32'(grant),   32'h2);
    chk("t2_tx_id",   32'(tx_id),   32'h050);
    chk("t2_tx_data", 32'(tx_data), 32'h02);
    pulse_done();
    req = 4'b0000;
    chk("t2_done", 32'(done), 32'h2);
    wait_idle("t2_idle");

    // Test 3: retry limit
    set_mbox(0, 11'h100, 8'h5A);
    req = 4'b0001;
    wait_start(cyc);
    chk("t3_latency", 32'(cyc),   32'd2);
    chk("t3_grant",   32'(grant), 32'h1);
    pulse_lost();
    chk("t3_loss1_nofail", 32'(fail),  32'h0);
    chk("t3_loss1_grant",  32'(grant), 32'h0);
    wait_start(cyc);
    chk("t3_relaunch2", 32'(cyc), 32'd5);
    pulse_lost();
    chk("t3_loss2_nofail", 32'(fail), 32'h0);
    wait_start(cyc);
    chk("t3_relaunch3", 32'(cyc), 32'd5);
    pulse_lost();
    req = 4'b0000;
    chk("t3_fail",    32'(fail), 32'h1);
    chk("t3_no_done", 32'(done), 32'h0);
    @(negedge clk);
    chk("t3_fail_pulse", 32'(fail), 32'h0);
    wait_idle("t3_idle");

    // Test 4: preemption by a lower ID during GAP, then retry budget restarts
    set_mbox(0, 11'h200, 8'hC0);
    set_mbox(3, 11'h010, 8'h3C);
    req = 4'b0001;
    wait_start(cyc);
    chk("t4_grant0", 32'(grant), 32'h1);
    pulse_lost();
    req = 4'b1001;
    wait_start(cyc);
    chk("t4_pre_latency", 32'(cyc),     32'd5);
    chk("t4_pre_grant",   32'(grant),   32'h8);
    chk("t4_pre_tx_id",   32'(tx_id),   32'h010);
    chk("t4_pre_tx_data", 32'(tx_data), 32'h3C);
    pulse_done();
    req = 4'b0001;
    chk("t4_pre_done", 32'(done), 32'h8);
    wait_start(cyc);
    chk("t4_back_latency", 32'(cyc),   32'd5);
    chk("t4_back_grant",   32'(grant), 32'h1);
    chk("t4_back_tx_id",   32'(tx_id), 32'h200);
    pulse_lost();
    chk("t4_loss1_nofail", 32'(fail), 32'h0);
    wait_start(cyc);
    pulse_lost();
    chk("t4_loss2_nofail", 32'(fail), 32'h0);
    wait_start(cyc);
    pulse_lost();
    req = 4'b0000;
    chk("t4_loss3_fail", 32'(fail), 32'h1);
    wait_idle("t4_idle");

    // Test 5a: done and arbitration loss together
    set_mbox(2, 11'h0AA, 8'h77);
    req = 4'b0100;
    wait_start(cyc);
    chk("t5a_latency", 32'(cyc), 32'd2);
    tx_done     = 1'b1;
    tx_arb_lost = 1'b1;
    @(negedge clk);
    tx_done     = 1'b0;
    tx_arb_lost = 1'b0;
    req = 4'b0000;
    chk("t5a_done",    32'(done), 32'h4);
    chk("t5a_no_fail", 32'(fail), 32'h0);
    wait_idle("t5a_idle");
    pulse_lost();
    chk("t5a_idle_lost_ignored", 32'(busy), 32'h0);
    chk("t5a_idle_no_fail",      32'(fail), 32'h0);

    // Test 5b: watchdog timeout, then tx_done outside WAIT is ignored
    set_mbox(1, 11'h155, 8'h99);
    req = 4'b0010;
    wait_start(cyc);
    chk("t5b_latency", 32'(cyc), 32'd2);
    repeat (1022) @(negedge clk);
    chk("t5b_before_timeout_fail",  32'(fail),  32'h0);
    chk("t5b_before_timeout_grant", 32'(grant), 32'h2);
    @(negedge clk);
    chk("t5b_timeout_fail",  32'(fail),  32'h2);
    chk("t5b_timeout_done",  32'(done),  32'h0);
    chk("t5b_timeout_grant", 32'(grant), 32'h0);
    pulse_done();
    req = 4'b0000;
    chk("t5b_gap_done_ignored", 32'(done), 32'h0);
    wait_idle("t5b_idle");

    // Test 5c: asynchronous reset during WAIT
    set_mbox(3, 11'h0F0, 8'hE1);
    req = 4'b1000;
    wait_start(cyc);
    chk("t5c_latency", 32'(cyc),   32'd2);
    chk("t5c_grant",   32'(grant), 32'h8);
    reset_n = 1'b0;
    #1;
    chk("t5c_rst_tx_start", 32'(tx_start), 32'h0);
    chk("t5c_rst_grant",    32'(grant),    32'h0);
    chk("t5c_rst_busy",     32'(busy),     32'h0);
    chk("t5c_rst_tx_id",    32'(tx_id),    32'h0);
    @(negedge clk);
    chk("t5c_rst_done", 32'(done), 32'h0);
    chk("t5c_rst_fail", 32'(fail), 32'h0);
    reset_n = 1'b1;
    wait_start(cyc);
    chk("t5c_relaunch", 32'(cyc),   32'd2);
    chk("t5c_regrant",  32'(grant), 32'h8);
    chk("t5c_tx_id",    32'(tx_id), 32'h0F0);
    pulse_done();
    req = 4'b0000;
    chk("t5c_done", 32'(done), 32'h8);
    wait_idle("t5c_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
